ccm_preload: RTL

CCM_PRELOAD -- requirements
Module: ccm_preload

---
 rtl/ccm_preload_pkg.sv | 17 +
 rtl/ccm_preload.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ccm_preload_pkg.sv
// Shared types and constants for the CCM preloader.
// Line geometry is fixed: 16 bytes per line, split into two 64-bit bank words.
package ccm_preload_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 64;
    localparam int BYTES_PER_LINE = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

endpackage

// File: rtl/ccm_preload.sv
// CCM preloader: packs an ascending byte stream into 128-bit lines, writes even/odd banks.
// Build option CCM_PRELOAD_ZEROFILL_EN zeroes every line after the image before done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_FILL  | accepting bytes into the line buffer
// S_WRITE | single-cycle write of the assembled line to both banks
// S_CLEAR | zero-fill of remaining lines (zero-fill build only)
// S_DONE  | load complete, core released; only reset leaves
module ccm_preload
    import ccm_preload_pkg::*;
#(
    parameter int  DP = 2048,
    localparam int AW = $clog2(DP)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              eve_we,
    output logic              odd_we,
    output logic [AW-1:0]     eve_addr,
    output logic [AW-1:0]     odd_addr,
    output logic [WORD_W-1:0] eve_data,
    output logic [WORD_W-1:0] odd_data,
    output logic              core_rstn,
    output logic              done,
    output logic              ovf
);

    localparam int BCW = $clog2(BYTES_PER_LINE);
    localparam logic [AW-1:0]  LAST_LINE = AW'(DP - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_LINE - 1);

    state_t            state, state_nx;
    logic [AW-1:0]     line_cnt;
    logic [BCW-1:0]    byte_cnt;
    logic [LINE_W-1:0] line_buf;
    logic              last_seen;
    logic              accept;

    assign accept = (state == S_FILL) && in_valid;

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FILL;
            S_FILL:  if (accept && (byte_cnt == LAST_BYTE || in_last)) state_nx = S_WRITE;
            S_WRITE: begin
                if (last_seen) begin
`ifdef CCM_PRELOAD_ZEROFILL_EN
                    state_nx = (line_cnt == LAST_LINE) ? S_DONE : S_CLEAR;
`else
                    state_nx = S_DONE;
`endif
                end else if (line_cnt == LAST_LINE) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_FILL;
                end
            end
`ifdef CCM_PRELOAD_ZEROFILL_EN
            S_CLEAR: if (line_cnt == LAST_LINE) state_nx = S_DONE;
`endif
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            line_cnt  <= '0;
            byte_cnt  <= '0;
            line_buf  <= '0;
            last_seen <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        line_cnt  <= '0;
                        byte_cnt  <= '0;
                        line_buf  <= '0;
                        last_seen <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        line_buf[{byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt  <= byte_cnt + 1'b1;
                        last_seen <= in_last;
                    end
                end
                S_WRITE: begin
                    // Counter may wrap at the last line; the FSM leaves for DONE then anyway.
                    line_cnt <= line_cnt + 1'b1;
                    byte_cnt <= '0;
                    line_buf <= '0;
                    if (!last_seen && line_cnt == LAST_LINE) ovf <= 1'b1;
                end
                S_CLEAR: line_cnt <= line_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_FILL);
        eve_we    = (state == S_WRITE) || (state == S_CLEAR);
        odd_we    = eve_we;
        eve_addr  = line_cnt;
        odd_addr  = line_cnt;
        eve_data  = (state == S_WRITE) ? line_buf[WORD_W-1:0] : '0;
        odd_data  = (state == S_WRITE) ? line_buf[LINE_W-1:WORD_W] : '0;
        done      = (state == S_DONE);
        core_rstn = (state == S_DONE);
    end

endmodule
